// File: rtl/ajuste_hora.sv
// ajuste_hora: two-button time-setting controller for an HH:MM clock.
// The mode button walks RUN -> SET_H -> SET_M -> COMMIT -> RUN; the inc
// button advances the field being edited in BCD. COMMIT issues a one-cycle
// load strobe so the hour/minute counters take the edited value.

// Button front end: 2-flop synchronizer, level debouncer, rising-edge pulse.
module ajuste_hora_btn #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [1:0]    sync;
  logic          level;
  logic          level_q;
  logic [DW-1:0] cnt;

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  // Accept a new level only after it has disagreed with the held level for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync[1] != level) begin
      if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        level <= level;
        cnt   <= cnt + DW'(1);
      end
    end else begin
      level <= level;
      cnt   <= '0;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // One pulse per accepted press, however long the button is held.
  assign press = level & ~level_q;

endmodule

// Top level: edit FSM, BCD editing registers and blink generator.
module ajuste_hora #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_HALF      = 12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_h_msd,
  input  logic [3:0] cur_h_lsd,
  input  logic [2:0] cur_m_msd,
  input  logic [3:0] cur_m_lsd,
  output logic [1:0] set_h_msd,
  output logic [3:0] set_h_lsd,
  output logic [2:0] set_m_msd,
  output logic [3:0] set_m_lsd,
  output logic       load,
  output logic       editing,
  output logic       blink_h,
  output logic       blink_m
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          mode_evt;
  logic          inc_evt;
  logic [1:0]    h_msd_next;
  logic [3:0]    h_lsd_next;
  logic [2:0]    m_msd_next;
  logic [3:0]    m_lsd_next;
  logic [5:0]    hour_plus;
  logic [6:0]    minute_plus;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_next;
  logic          phase;
  logic          phase_next;

  // Next BCD hour {msd, lsd}; anything at or past 23 (including captured
  // garbage such as 3x or a non-decimal digit) wraps to 00.
  function automatic logic [5:0] hour_inc(input logic [1:0] msd, input logic [3:0] lsd);
    logic [5:0] r;
    if ((lsd > 4'd9) || (msd == 2'd3) || ((msd == 2'd2) && (lsd >= 4'd3))) begin
      r = 6'd0;
    end else if (lsd == 4'd9) begin
      r = {msd + 2'd1, 4'd0};
    end else begin
      r = {msd, lsd + 4'd1};
    end
    return r;
  endfunction

  // Next BCD minute {msd, lsd}; 59 and anything out of range wrap to 00.
  function automatic logic [6:0] minute_inc(input logic [2:0] msd, input logic [3:0] lsd);
    logic [6:0] r;
    if ((lsd > 4'd9) || (msd > 3'd5) || ((msd == 3'd5) && (lsd == 4'd9))) begin
      r = 7'd0;
    end else if (lsd == 4'd9) begin
      r = {msd + 3'd1, 4'd0};
    end else begin
      r = {msd, lsd + 4'd1};
    end
    return r;
  endfunction

  ajuste_hora_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clock (clock),
    .reset (reset),
    .raw   (btn_mode),
    .press (mode_evt)
  );

  ajuste_hora_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
    .clock (clock),
    .reset (reset),
    .raw   (btn_inc),
    .press (inc_evt)
  );

  assign hour_plus   = hour_inc(set_h_msd, set_h_lsd);
  assign minute_plus = minute_inc(set_m_msd, set_m_lsd);

  // Edit sequence: each mode press moves one step; COMMIT lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (mode_evt) next_state = SET_H;
        else          next_state = RUN;
      end
      SET_H: begin
        if (mode_evt) next_state = SET_M;
        else          next_state = SET_H;
      end
      SET_M: begin
        if (mode_evt) next_state = COMMIT;
        else          next_state = SET_M;
      end
      COMMIT: begin
        next_state = RUN;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Editing value: capture on entry, increment the active field; a mode
  // press in the same cycle as an inc press wins and the inc is dropped.
  always_comb begin
    h_msd_next = set_h_msd;
    h_lsd_next = set_h_lsd;
    m_msd_next = set_m_msd;
    m_lsd_next = set_m_lsd;
    case (state)
      RUN: begin
        if (mode_evt) begin
          h_msd_next = cur_h_msd;
          h_lsd_next = cur_h_lsd;
          m_msd_next = cur_m_msd;
          m_lsd_next = cur_m_lsd;
        end else begin
          h_msd_next = set_h_msd;
        end
      end
      SET_H: begin
        if (!mode_evt && inc_evt) begin
          h_msd_next = hour_plus[5:4];
          h_lsd_next = hour_plus[3:0];
        end else begin
          h_msd_next = set_h_msd;
        end
      end
      SET_M: begin
        if (!mode_evt && inc_evt) begin
          m_msd_next = minute_plus[6:4];
          m_lsd_next = minute_plus[3:0];
        end else begin
          m_msd_next = set_m_msd;
        end
      end
      default: begin
        h_msd_next = set_h_msd;
      end
    endcase
  end

  // Editing value registers, which drive the set_* outputs directly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      set_h_msd <= 2'd0;
      set_h_lsd <= 4'd0;
      set_m_msd <= 3'd0;
      set_m_lsd <= 4'd0;
    end else begin
      set_h_msd <= h_msd_next;
      set_h_lsd <= h_lsd_next;
      set_m_msd <= m_msd_next;
      set_m_lsd <= m_lsd_next;
    end
  end

  // Blink timebase: restarts with phase 0 whenever the state changes so the
  // newly selected field always starts visible.
  always_comb begin
    blink_cnt_next = blink_cnt;
    phase_next     = phase;
    if (next_state != state) begin
      blink_cnt_next = '0;
      phase_next     = 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt_next = '0;
      phase_next     = ~phase;
    end else begin
      blink_cnt_next = blink_cnt + BW'(1);
      phase_next     = phase;
    end
  end

  // Blink counter, phase and the per-field blank requests.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
      blink_h   <= 1'b0;
      blink_m   <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_next;
      phase     <= phase_next;
      blink_h   <= (next_state == SET_H) & phase_next;
      blink_m   <= (next_state == SET_M) & phase_next;
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load    <= 1'b0;
      editing <= 1'b0;
    end else begin
      load    <= (next_state == COMMIT);
      editing <= (next_state != RUN);
    end
  end

endmodule
